// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side sequencer of the UART. It synchronises the rx pin, drives the
// enable_half/enable_max inputs of the neighbouring RX baud counter, consumes
// the counter's flag, and frames one asynchronous character into a parallel
// word with ready / framing / parity / overrun status.
//
// Frame format: start, DATA_BITS data bits LSB first, optional parity, stop.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : PARITY state present, parity_error = par ^ (^data) ^ PARITY_ODD
//   undefined : DATA goes straight to STOP, parity_error tied to 0
// ----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 baud_flag,
  input  logic                 rx_clear,
  output logic                 enable_half,
  output logic                 enable_max,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun_error,
  output logic                 busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    , ST_PARITY = 3'd5
`endif
  } state_t;

  // Index of the last data bit; bit_cnt_r counts the data bits already shifted.
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // Parity check: 1 when the received parity bit does not match the data.
  function automatic logic calc_parity_error(input logic [DATA_BITS-1:0] data,
                                             input logic par);
    return par ^ (^data) ^ PARITY_ODD;
  endfunction

  logic                 rx_meta_r;
  logic                 rx_sync_r;
  state_t               state_r;
  state_t               state_nxt_s;
  logic [2:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shreg_r;
  logic                 tick_s;
  logic                 shift_s;
  logic                 load_s;
  logic                 clr_cnt_s;
  logic                 par_cap_s;
  logic                 parity_nxt_s;
  logic                 en_max_nxt_s;

`ifdef UART_RX_PARITY_EN
  logic                 par_bit_r;
`endif

  // A baud event only counts while this block has the counter enabled.
  assign tick_s = baud_flag & (enable_half | enable_max);

  // Two-flop synchroniser for the asynchronous rx pin; resets to line idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and datapath strobes; moves only on tick except from IDLE/BREAK.
  always_comb begin
    state_nxt_s = state_r;
    shift_s     = 1'b0;
    load_s      = 1'b0;
    clr_cnt_s   = 1'b0;
    par_cap_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_sync_r) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          if (!rx_sync_r) begin
            state_nxt_s = ST_DATA;
            clr_cnt_s   = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_s = 1'b1;
          if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_STOP;
`endif
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          par_cap_s   = 1'b1;
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          load_s = 1'b1;
          if (rx_sync_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_BREAK;
          end
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rx_sync_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Full-bit enable decode of the upcoming state so it lines up with the state.
  always_comb begin
    en_max_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_DATA:   en_max_nxt_s = 1'b1;
      ST_STOP:   en_max_nxt_s = 1'b1;
`ifdef UART_RX_PARITY_EN
      ST_PARITY: en_max_nxt_s = 1'b1;
`endif
      default:   en_max_nxt_s = 1'b0;
    endcase
  end

  // Registered baud-counter enables and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_half <= 1'b0;
      enable_max  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      enable_half <= (state_nxt_s == ST_START);
      enable_max  <= en_max_nxt_s;
      busy        <= (state_nxt_s != ST_IDLE);
    end
  end

  // Data bit counter and LSB-first shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_r <= 3'd0;
      shreg_r   <= '0;
    end else if (clr_cnt_s) begin
      bit_cnt_r <= 3'd0;
    end else if (shift_s) begin
      bit_cnt_r <= bit_cnt_r + 3'd1;
      shreg_r   <= {rx_sync_r, shreg_r[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Capture the received parity bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bit_r <= 1'b0;
    end else if (par_cap_s) begin
      par_bit_r <= rx_sync_r;
    end
  end

  // Parity result presented at the stop-bit load.
  always_comb begin
    parity_nxt_s = calc_parity_error(shreg_r, par_bit_r);
  end
`else
  // Parity is not checked in this build.
  always_comb begin
    parity_nxt_s = 1'b0;
  end
`endif

  // Status and output word; a load in the same cycle as rx_clear takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data       <= '0;
      rx_ready      <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
    end else if (load_s) begin
      rx_data       <= shreg_r;
      rx_ready      <= 1'b1;
      framing_error <= ~rx_sync_r;
      parity_error  <= parity_nxt_s;
      overrun_error <= overrun_error | rx_ready;
    end else if (rx_clear) begin
      rx_ready      <= 1'b0;
      overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Drives serial frames onto rx (434 clk per bit), models the neighbouring baud
// counter, and checks every completed receive episode against a status model
// kept as plain variables. Expected snapshots are queued when a frame or
// glitch is issued; a monitor pops one whenever busy falls.
// Define UART_RX_PARITY_EN for both RTL and bench to exercise parity.
// ----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int DATA_BITS  = 8;
  localparam bit PARITY_ODD = 1'b0;
  localparam int BIT_CLKS   = 434;
  localparam int HALF_CLKS  = 217;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       baud_flag;
  logic       rx_clear = 1'b0;
  logic       enable_half, enable_max;
  logic [7:0] rx_data;
  logic       rx_ready, framing_error, parity_error, overrun_error, busy;

  uart_rx_ctrl #(.DATA_BITS(DATA_BITS), .PARITY_ODD(PARITY_ODD)) dut (
    .clk(clk), .reset(reset), .rx(rx), .baud_flag(baud_flag), .rx_clear(rx_clear),
    .enable_half(enable_half), .enable_max(enable_max), .rx_data(rx_data),
    .rx_ready(rx_ready), .framing_error(framing_error), .parity_error(parity_error),
    .overrun_error(overrun_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Baud counter beside the sequencer: cleared while idle, wraps on its flag.
  int cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) cnt <= 0;
    else if (!(enable_half || enable_max)) cnt <= 0;
    else if (baud_flag) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign baud_flag = (enable_half && cnt == HALF_CLKS - 1) || (enable_max && cnt == BIT_CLKS - 1);

  typedef struct {
    logic [7:0] data;
    logic       ready;
    logic       fe;
    logic       pe;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference status model
  logic [7:0] m_data = 8'h00;
  logic       m_ready = 1'b0, m_fe = 1'b0, m_pe = 1'b0, m_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.data = m_data; e.ready = m_ready; e.fe = m_fe; e.pe = m_pe; e.ovr = m_ovr;
    return e;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, data bits LSB first, optional parity bit.
  task automatic send_head(input logic [7:0] d, input logic par);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    wait_clks(BIT_CLKS);
`else
    if (par) rx = 1'b1;
`endif
  endtask

  task automatic send_bits(input logic [7:0] d, input logic par, input logic stop_ok);
    send_head(d, par);
    rx = stop_ok;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(8);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop_ok);
    m_ovr   = m_ovr | m_ready;
    m_ready = 1'b1;
    m_data  = d;
    m_fe    = ~stop_ok;
`ifdef UART_RX_PARITY_EN
    m_pe    = par ^ (^d) ^ PARITY_ODD;
`else
    m_pe    = 1'b0;
`endif
    exp_q.push_back(snapshot());
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_ok);
    model_frame(d, par, stop_ok);
    send_bits(d, par, stop_ok);
  endtask

  task automatic do_clear();
    rx_clear = 1'b1;
    wait_clks(1);
    rx_clear = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic glitch(input int len);
    exp_q.push_back(snapshot());
    rx = 1'b0;
    wait_clks(len);
    rx = 1'b1;
    wait_clks(300);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  // Monitor: compare each finished episode against the queued expectation.
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    chk("enables_exclusive", {31'd0, enable_half & enable_max}, 32'd0);
    if (!reset) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_episode", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ep_rx_data", {24'd0, rx_data}, {24'd0, e.data});
          chk("ep_rx_ready", {31'd0, rx_ready}, {31'd0, e.ready});
          chk("ep_framing", {31'd0, framing_error}, {31'd0, e.fe});
          chk("ep_parity", {31'd0, parity_error}, {31'd0, e.pe});
          chk("ep_overrun", {31'd0, overrun_error}, {31'd0, e.ovr});
        end
      end
      prev_busy = busy;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    chk({tag, "_status"}, {27'd0, rx_ready, framing_error, parity_error, overrun_error, busy}, 32'd0);
    chk({tag, "_enables"}, {30'd0, enable_half, enable_max}, 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] d;

    // Reset state
    wait_clks(5);
    chk_all_zero("reset");
    reset = 1'b1;
    wait_clks(10);

    // 0xA5 8N1 with latency measurement
    fork
      send_frame(8'hA5, good_par(8'hA5), 1'b1);
      begin
        n = 0;
        while (n < 6000) begin
          @(posedge clk);
          n++;
          @(negedge clk);
          if (rx_ready) break;
        end
        chk("latency_4126", {31'd0, (n >= 4125 && n <= 4127)}, 32'd1);
      end
    join
    do_clear();
    @(negedge clk);
    chk("clear_ready", {31'd0, rx_ready}, 32'd0);
    #1;
    wait_clks(5);

    // Short low pulse: aborted at half bit
    glitch(100);
    chk("glitch_idle", {30'd0, busy, rx_ready}, 32'd0);

    // Framing error with line held low
    model_frame(8'h3C, good_par(8'h3C), 1'b0);
    send_head(8'h3C, good_par(8'h3C));
    rx = 1'b0;
    wait_clks(1000);
    chk("break_busy", {29'd0, busy, enable_half, enable_max}, 32'd4);
    wait_clks(1000);
    chk("break_hold", {30'd0, busy, framing_error}, 32'd3);
    rx = 1'b1;
    wait_clks(10);
    chk("break_exit", {31'd0, busy}, 32'd0);
    do_clear();
    wait_clks(5);

    // Overrun: two frames without clear
    send_frame(8'h11, good_par(8'h11), 1'b1);
    send_frame(8'h22, good_par(8'h22), 1'b1);
    do_clear();
    @(negedge clk);
    chk("ovr_clear", {30'd0, rx_ready, overrun_error}, 32'd0);
    chk("ovr_data_held", {24'd0, rx_data}, 32'h22);
    #1;
    wait_clks(5);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    do_clear();
    send_frame(8'h07, 1'b1, 1'b1);
    do_clear();
`endif

    // Reset during bit 4 of 0xFF
    fork
      send_bits(8'hFF, 1'b1, 1'b1);
      begin
        wait_clks(BIT_CLKS * 5 + 200);
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        wait_clks(3);
        reset = 1'b1;
        m_data = 8'h00; m_ready = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ovr = 1'b0;
      end
    join
    wait_clks(5);
    send_frame(8'h5A, good_par(8'h5A), 1'b1);

    // Randomised frames
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) do_clear();
      if ($urandom_range(0, 9) < 3) glitch($urandom_range(20, 180));
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0));
      wait_clks($urandom_range(0, 50));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      wait_clks(1);
      n++;
    end
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
